seq_step_monitor: RTL and testbench
===================================

Name: seq_step_monitor

Overview:
- Synthesisable on-chip version of the step/acknowledge progress check used by the LA test flow.
- Watches a step-code bus and an acknowledge bus and checks that codes 1..LAST_STEP arrive in order, each followed by an idle acknowledge.
- Reports pass/fail, the current step and a fail reason.
- Sits in the user project area; inputs may come from pads or LA lines, so they are synchronised internally.
- Generalises the fixed 6-bit/32-step/2-bit-ack check with parametrised widths, step count, timeout and optional strict ordering.

Parameters:
- CODE_W, 6, width of step-code bus.
- ACK_W, 2, width of acknowledge bus.
- ACK_IDLE, 0, ack value meaning "step consumed".
- LAST_STEP, 32, final expected code; legal range 1..2^CODE_W-1.
- SYNC_STAGES, 2, synchroniser depth on code_i/ack_i; legal range 2..4.
- TMO_W, 20, width of timeout counter.
- TMO_CYCLES, 200000, cycles allowed per phase before timeout; must fit in TMO_W.

Ports:
- clock  in  1  system clock.
- resetb  in  1  asynchronous active-low reset.
- start_i  in  1  one-cycle pulse; arms the monitor from IDLE, PASS or FAIL.
- abort_i  in  1  returns to IDLE from any state; no pass/fail is reported.
- code_i  in  CODE_W  step code, asynchronous to clock.
- ack_i  in  ACK_W  acknowledge, asynchronous to clock.
- busy_o  out  1  high while in WAIT_CODE or WAIT_ACK.
- pass_o  out  1  sticky; high in PASS.
- fail_o  out  1  sticky; high in FAIL.
- fail_code_o  out  2  00 none, 01 timeout, 10 out-of-order, 11 ack-before-code.
- cur_step_o  out  CODE_W  expected step code.

Behaviour:

Reset and input conditioning:
- Reset values: state IDLE; busy_o, pass_o and fail_o are 0; fail_code_o is 00; cur_step_o is 0; timeout counter is 0; synchroniser flops are 0.
- code_i and ack_i each pass through SYNC_STAGES flops.
- A "stable" value is a synchronised value equal on two consecutive cycles. All decisions use stable values only, which acts as a glitch filter.

State IDLE:
- On start_i: cur_step_o is set to 1, the counter is cleared, and the state moves to WAIT_CODE.

State WAIT_CODE:
- Stable code equal to cur_step_o: go to WAIT_ACK and clear the counter.
- Stable ack not equal to ACK_IDLE while code is not yet matched: no effect. The ack is only checked in WAIT_ACK.
- Counter reaches TMO_CYCLES-1: go to FAIL with fail_code 01.

State WAIT_ACK:
- Stable ack equal to ACK_IDLE:
  - If cur_step_o == LAST_STEP, go to PASS.
  - Otherwise increment cur_step_o, go to WAIT_CODE and clear the counter.
- Counter reaches TMO_CYCLES-1: go to FAIL with fail_code 01.

States PASS and FAIL:
- Hold all outputs.
- start_i re-arms the monitor: flags and fail_code are cleared in the same cycle and the state moves to WAIT_CODE with step 1.

Latency and timing:
- A code change on the pin is recognised after SYNC_STAGES+1 cycles. The state update happens on the next clock edge.

Simultaneous events and boundary conditions:
- abort_i has priority over start_i. start_i has priority over any timeout or match in the same cycle.
- cur_step_o never wraps, because LAST_STEP is at most 2^CODE_W-1.
- The timeout counter saturates and does not wrap.
- Reset mid-operation immediately forces the reset values.

Optional Feature:
- Macro: SEQ_STEP_MON_STRICT_EN.
- Defined, in WAIT_CODE:
  - A stable code that is not 0, not cur_step_o and not cur_step_o-1 goes to FAIL with fail_code 10. cur_step_o-1 is allowed as the previous step code still being held.
  - A stable code equal to cur_step_o while ack equals ACK_IDLE is accepted.
- Defined, in WAIT_ACK:
  - A stable code change to any value other than cur_step_o before the ack goes idle gives FAIL with fail_code 11.
- Undefined:
  - Non-matching codes are ignored, so the monitor waits, and fail_code values 10 and 11 are never produced.
  - The ordering comparators are not synthesised.

Test Plan:
1. Reset released, start pulse, then drive codes 1..32 on code_i, each held 10 cycles with ack=00 -> cur_step_o counts 1..32, pass_o=1 about 4 cycles after the last code, fail_o=0.
2. TMO_CYCLES=100, start pulse, code held at 0 -> fail_o=1 and fail_code_o=01 exactly 100 cycles after WAIT_CODE entry; busy_o=0.
3. STRICT_EN, sequence 1,2 then 5 -> fail_o=1, fail_code_o=10, cur_step_o=3.
4. STRICT off, same sequence 1,2,5,3 -> 5 ignored; the run continues to pass at step 32.
5. A 1-cycle glitch code=3 while cur_step_o=3 in WAIT_CODE -> not accepted, state unchanged. A 2-cycle-stable code of 3 -> accepted.
6. abort_i asserted at step 10, resetb pulsed mid-run at step 20, and start_i asserted while in FAIL -> each returns to IDLE, the reset values, or WAIT_CODE with step 1 respectively; flags are cleared in all three cases.

Source files
------------

// File: rtl/seq_step_monitor.sv
// Step/acknowledge progress monitor: checks codes 1..LAST_STEP arrive in order, each followed by an idle ack.
// Optional macro SEQ_STEP_MON_STRICT_EN adds out-of-order (10) and ack-before-code (11) failure detection.
module seq_step_monitor #(
    parameter int CODE_W      = 6,
    parameter int ACK_W       = 2,
    parameter int ACK_IDLE    = 0,
    parameter int LAST_STEP   = 32,
    parameter int SYNC_STAGES = 2,
    parameter int TMO_W       = 20,
    parameter int TMO_CYCLES  = 200000
) (
    input  logic              clock,
    input  logic              resetb,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic [CODE_W-1:0] code_i,
    input  logic [ACK_W-1:0]  ack_i,
    output logic              busy_o,
    output logic              pass_o,
    output logic              fail_o,
    output logic [1:0]        fail_code_o,
    output logic [CODE_W-1:0] cur_step_o
);

    localparam logic [CODE_W-1:0] LAST_C     = CODE_W'(LAST_STEP);
    localparam logic [ACK_W-1:0]  ACK_IDLE_C = ACK_W'(ACK_IDLE);
    localparam logic [TMO_W-1:0]  TMO_LAST   = TMO_W'(TMO_CYCLES - 1);

    localparam logic [1:0] FC_NONE    = 2'b00;
    localparam logic [1:0] FC_TIMEOUT = 2'b01;
`ifdef SEQ_STEP_MON_STRICT_EN
    localparam logic [1:0] FC_ORDER   = 2'b10;
    localparam logic [1:0] FC_EARLY   = 2'b11;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_CODE,
        S_WAIT_ACK,
        S_PASS,
        S_FAIL
    } state_t;

    logic [SYNC_STAGES-1:0][CODE_W-1:0] code_sync_q;
    logic [SYNC_STAGES-1:0][ACK_W-1:0]  ack_sync_q;
    logic [CODE_W-1:0]                  code_prev_q;
    logic [ACK_W-1:0]                   ack_prev_q;

    state_t            state_q, state_d;
    logic [CODE_W-1:0] step_q, step_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic [1:0]        fail_code_q, fail_code_d;

    logic [CODE_W-1:0] code_s;
    logic [ACK_W-1:0]  ack_s;
    logic              code_stable;
    logic              ack_stable;
    logic              code_match;
    logic              ack_done;
    logic              tmo_expired;
    logic [TMO_W-1:0]  tmo_inc;

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            code_sync_q <= '0;
            ack_sync_q  <= '0;
            code_prev_q <= '0;
            ack_prev_q  <= '0;
        end else begin
            code_sync_q <= {code_sync_q[SYNC_STAGES-2:0], code_i};
            ack_sync_q  <= {ack_sync_q[SYNC_STAGES-2:0], ack_i};
            code_prev_q <= code_sync_q[SYNC_STAGES-1];
            ack_prev_q  <= ack_sync_q[SYNC_STAGES-1];
        end
    end

    // A value only counts once it has been seen on two consecutive cycles.
    assign code_s      = code_sync_q[SYNC_STAGES-1];
    assign ack_s       = ack_sync_q[SYNC_STAGES-1];
    assign code_stable = (code_s == code_prev_q);
    assign ack_stable  = (ack_s == ack_prev_q);
    assign code_match  = code_stable && (code_s == step_q);
    assign ack_done    = ack_stable && (ack_s == ACK_IDLE_C);
    assign tmo_expired = (tmo_q >= TMO_LAST);
    assign tmo_inc     = (tmo_q == '1) ? tmo_q : tmo_q + 1'b1;

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            state_q     <= S_IDLE;
            step_q      <= '0;
            tmo_q       <= '0;
            fail_code_q <= FC_NONE;
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            tmo_q       <= tmo_d;
            fail_code_q <= fail_code_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        step_d      = step_q;
        tmo_d       = tmo_q;
        fail_code_d = fail_code_q;
        if (abort_i) begin
            state_d     = S_IDLE;
            step_d      = '0;
            tmo_d       = '0;
            fail_code_d = FC_NONE;
        end else if (start_i) begin
            state_d     = S_WAIT_CODE;
            step_d      = CODE_W'(1);
            tmo_d       = '0;
            fail_code_d = FC_NONE;
        end else begin
            case (state_q)
                S_WAIT_CODE: begin
                    tmo_d = tmo_inc;
                    if (code_match) begin
                        state_d = S_WAIT_ACK;
                        tmo_d   = '0;
`ifdef SEQ_STEP_MON_STRICT_EN
                    // The previous step's code may still be held while the source moves on.
                    end else if (code_stable && (code_s != '0) &&
                                 (code_s != step_q - CODE_W'(1))) begin
                        state_d     = S_FAIL;
                        fail_code_d = FC_ORDER;
`endif
                    end else if (tmo_expired) begin
                        state_d     = S_FAIL;
                        fail_code_d = FC_TIMEOUT;
                    end
                end
                S_WAIT_ACK: begin
                    tmo_d = tmo_inc;
                    if (ack_done) begin
                        if (step_q == LAST_C) begin
                            state_d = S_PASS;
                        end else begin
                            state_d = S_WAIT_CODE;
                            step_d  = step_q + CODE_W'(1);
                            tmo_d   = '0;
                        end
`ifdef SEQ_STEP_MON_STRICT_EN
                    end else if (code_stable && (code_s != step_q)) begin
                        state_d     = S_FAIL;
                        fail_code_d = FC_EARLY;
`endif
                    end else if (tmo_expired) begin
                        state_d     = S_FAIL;
                        fail_code_d = FC_TIMEOUT;
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    always_comb begin
        busy_o      = (state_q == S_WAIT_CODE) || (state_q == S_WAIT_ACK);
        pass_o      = (state_q == S_PASS);
        fail_o      = (state_q == S_FAIL);
        fail_code_o = fail_code_q;
        cur_step_o  = step_q;
    end

endmodule

// File: tb/tb_seq_step_monitor.sv
// Bench for seq_step_monitor: vector table for reset/timeout/abort/re-arm, scoreboard of step progression.
module tb_seq_step_monitor;

    logic       clock = 1'b0;
    logic       resetb;
    logic       start_i;
    logic       abort_i;
    logic [5:0] code_i;
    logic [1:0] ack_i;
    logic       busy_o;
    logic       pass_o;
    logic       fail_o;
    logic [1:0] fail_code_o;
    logic [5:0] cur_step_o;

    seq_step_monitor #(
        .CODE_W(6), .ACK_W(2), .ACK_IDLE(0), .LAST_STEP(32),
        .SYNC_STAGES(2), .TMO_W(20), .TMO_CYCLES(100)
    ) dut (
        .clock(clock), .resetb(resetb), .start_i(start_i), .abort_i(abort_i),
        .code_i(code_i), .ack_i(ack_i), .busy_o(busy_o), .pass_o(pass_o),
        .fail_o(fail_o), .fail_code_o(fail_code_o), .cur_step_o(cur_step_o)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic       start;
        logic       abort;
        int         n;
        logic       busy;
        logic       pass;
        logic       fail;
        logic [1:0] fc;
        logic [5:0] step;
    } vec_t;

    vec_t       vecs [9];
    int         n_checks = 0;
    int         n_fail   = 0;
    logic [5:0] model_step = 6'd0;
    logic [5:0] last_step  = 6'd0;
    logic [5:0] exp_q [$];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick_mon();
        logic [5:0] e;
        tick();
        if (cur_step_o !== last_step) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL step_seq: got unexpected step %0d, expected no change from %0d",
                         cur_step_o, last_step);
            end else begin
                e = exp_q.pop_front();
                check("step_seq", cur_step_o, e);
            end
            last_step = cur_step_o;
        end
    endtask

    task automatic drive_code(input logic [5:0] k, input int n);
        code_i = k;
        if (k != 6'd0 && k == model_step && model_step < 6'd32) begin
            model_step = model_step + 6'd1;
            exp_q.push_back(model_step);
        end
        repeat (n) tick_mon();
    endtask

    task automatic drive_raw(input logic [5:0] k, input int n);
        code_i = k;
        repeat (n) tick_mon();
    endtask

    task automatic pulse_start();
        start_i = 1'b1;
        if (model_step != 6'd1) exp_q.push_back(6'd1);
        model_step = 6'd1;
        tick_mon();
        start_i = 1'b0;
    endtask

    task automatic check_outs(input string name, input logic busy, input logic pass,
                              input logic fail, input logic [1:0] fc, input logic [5:0] step);
        check({name, "_busy"}, busy_o, busy);
        check({name, "_pass"}, pass_o, pass);
        check({name, "_fail"}, fail_o, fail);
        check({name, "_fc"}, fail_code_o, fc);
        check({name, "_step"}, cur_step_o, step);
    endtask

    initial begin
        //           start abort  n   busy pass fail fc     step
        vecs[0] = '{1'b0, 1'b0, 1,  1'b0, 1'b0, 1'b0, 2'b00, 6'd0};
        vecs[1] = '{1'b1, 1'b0, 1,  1'b1, 1'b0, 1'b0, 2'b00, 6'd1};
        vecs[2] = '{1'b0, 1'b0, 99, 1'b1, 1'b0, 1'b0, 2'b00, 6'd1};
        vecs[3] = '{1'b0, 1'b0, 1,  1'b0, 1'b0, 1'b1, 2'b01, 6'd1};
        vecs[4] = '{1'b0, 1'b0, 5,  1'b0, 1'b0, 1'b1, 2'b01, 6'd1};
        vecs[5] = '{1'b1, 1'b0, 1,  1'b1, 1'b0, 1'b0, 2'b00, 6'd1};
        vecs[6] = '{1'b0, 1'b1, 1,  1'b0, 1'b0, 1'b0, 2'b00, 6'd0};
        vecs[7] = '{1'b1, 1'b1, 1,  1'b0, 1'b0, 1'b0, 2'b00, 6'd0};
        vecs[8] = '{1'b0, 1'b0, 10, 1'b0, 1'b0, 1'b0, 2'b00, 6'd0};

        resetb  = 1'b0;
        start_i = 1'b0;
        abort_i = 1'b0;
        code_i  = 6'd0;
        ack_i   = 2'b00;
        repeat (3) tick();
        resetb = 1'b1;

        // Reset state, exact timeout, sticky FAIL, re-arm from FAIL, abort priority.
        for (int i = 0; i < 9; i++) begin
            start_i = vecs[i].start;
            abort_i = vecs[i].abort;
            repeat (vecs[i].n) tick();
            check_outs($sformatf("vec%0d", i), vecs[i].busy, vecs[i].pass,
                       vecs[i].fail, vecs[i].fc, vecs[i].step);
        end
        start_i    = 1'b0;
        abort_i    = 1'b0;
        model_step = 6'd0;
        last_step  = 6'd0;

        // Full in-order run.
        drive_code(6'd0, 5);
        pulse_start();
        for (int k = 1; k <= 32; k++) drive_code(6'(k), 10);
        check_outs("full_run", 1'b0, 1'b1, 1'b0, 2'b00, 6'd32);

        // Glitch filter, re-arm from PASS.
        drive_code(6'd0, 5);
        pulse_start();
        drive_code(6'd1, 10);
        drive_code(6'd2, 10);
        drive_raw(6'd3, 1);
        drive_code(6'd2, 8);
        check_outs("glitch", 1'b1, 1'b0, 1'b0, 2'b00, 6'd3);
        drive_code(6'd3, 2);
        drive_code(6'd0, 6);
        check_outs("two_cycle", 1'b1, 1'b0, 1'b0, 2'b00, 6'd4);

        // Abort at step 10.
        for (int k = 4; k <= 9; k++) drive_code(6'(k), 10);
        check("pre_abort_step", cur_step_o, 6'd10);
        abort_i = 1'b1;
        exp_q.push_back(6'd0);
        model_step = 6'd0;
        tick_mon();
        abort_i = 1'b0;
        check_outs("abort", 1'b0, 1'b0, 1'b0, 2'b00, 6'd0);

        // Reset pulse at step 20.
        drive_code(6'd0, 5);
        pulse_start();
        for (int k = 1; k <= 19; k++) drive_code(6'(k), 10);
        check("pre_reset_step", cur_step_o, 6'd20);
        resetb = 1'b0;
        #1;
        check_outs("reset_mid", 1'b0, 1'b0, 1'b0, 2'b00, 6'd0);
        model_step = 6'd0;
        last_step  = 6'd0;
        repeat (2) tick();
        resetb = 1'b1;
        drive_code(6'd0, 5);
        check_outs("post_reset", 1'b0, 1'b0, 1'b0, 2'b00, 6'd0);

`ifdef SEQ_STEP_MON_STRICT_EN
        pulse_start();
        drive_code(6'd1, 10);
        drive_code(6'd2, 10);
        drive_code(6'd5, 10);
        check_outs("strict_order", 1'b0, 1'b0, 1'b1, 2'b10, 6'd3);
        drive_code(6'd0, 5);
        pulse_start();
        ack_i = 2'b01;
        drive_raw(6'd1, 10);
        check_outs("strict_wait_ack", 1'b1, 1'b0, 1'b0, 2'b00, 6'd1);
        drive_raw(6'd2, 10);
        check_outs("strict_early", 1'b0, 1'b0, 1'b1, 2'b11, 6'd1);
        ack_i = 2'b00;
`else
        pulse_start();
        drive_code(6'd1, 10);
        drive_code(6'd2, 10);
        drive_code(6'd5, 10);
        check_outs("lax_skip", 1'b1, 1'b0, 1'b0, 2'b00, 6'd3);
        for (int k = 3; k <= 32; k++) drive_code(6'(k), 10);
        check_outs("lax_run", 1'b0, 1'b1, 1'b0, 2'b00, 6'd32);
`endif

        check("queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
